freq_gate_ctrl: RTL

Gate-window controller for the frequency counter. It consumes the one-cycle leading-edge pulses from the edge detector and counts them over a fixed gate window of `GATE_CYCLES` clocks. At the end of each window it publishes the count with a valid strobe and restarts immediately, so no edge is lost between windows. It sits between the edge detector and the display/readout logic and is the only block that sequences measurement windows.

---
 rtl/freq_gate_if.sv | 54 +++++
 rtl/freq_gate_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_if.sv
// freq_gate_if: bundle between the edge-detector/readout side and freq_gate_ctrl.
//
// Signals:
//   enable       level, 1 runs back-to-back gate windows, 0 idles
//   edge_pulse   one-cycle pulse per leading edge, synchronous to clk
//   result       edges counted in the last completed window (saturated)
//   result_bcd   result in packed BCD, least significant digit in [3:0]
//   result_valid one-cycle publish strobe
//   overflow     last completed window saturated
//   busy         high while a window is being counted
//   state_dbg    controller state (0 = IDLE, 1 = COUNT) for observation
//
// Handshake: result_valid is a pure strobe with no ready/backpressure. In the
// cycle it is high, result/result_bcd/overflow already hold the new window's
// values; they stay stable until the next strobe, so a consumer may either
// capture on the strobe or sample the held values at any later time.
//
// Modports: master = producer of enable/edge_pulse (and reader of results),
//           slave  = freq_gate_ctrl.
interface freq_gate_if #(
  parameter int CNT_W  = 8,
  parameter int DIGITS = 3
);
  logic                  enable;
  logic                  edge_pulse;
  logic [CNT_W-1:0]      result;
  logic [4*DIGITS-1:0]   result_bcd;
  logic                  result_valid;
  logic                  overflow;
  logic                  busy;
  logic                  state_dbg;

  modport master (
    output enable,
    output edge_pulse,
    input  result,
    input  result_bcd,
    input  result_valid,
    input  overflow,
    input  busy,
    input  state_dbg
  );

  modport slave (
    input  enable,
    input  edge_pulse,
    output result,
    output result_bcd,
    output result_valid,
    output overflow,
    output busy,
    output state_dbg
  );
endinterface

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate-window controller for the frequency counter.
//
// Counts edge_pulse over back-to-back windows of GATE_CYCLES clocks and
// publishes the (saturated) count at the end of every window. The next
// window starts in the cycle after the terminal cycle, so no edge is lost.
//
// Parameters:
//   GATE_CYCLES  clocks per window, must be >= CNT_W+3
//   CNT_W        width of the edge count / result
//   DIGITS       BCD digits on result_bcd, 10^DIGITS > 2^CNT_W-1
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      freq_gate_if.slave (enable, edge_pulse in; result, result_bcd,
//            result_valid, overflow, busy, state_dbg out)
//
// Build option: define FREQ_GATE_BCD_EN to build a serial double-dabble
// converter. Publish then happens CNT_W+1 cycles after the terminal cycle and
// result_bcd carries the BCD value; otherwise result_bcd is tied to 0 and
// publish happens on the edge that ends the terminal cycle.
module freq_gate_ctrl #(
  parameter int GATE_CYCLES = 1200,
  parameter int CNT_W       = 8,
  parameter int DIGITS      = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  freq_gate_if.slave  bus
);

  localparam int GW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] edge_q;
  logic             sat_q;

  logic             terminal;   // last gate cycle of a window: publish
  logic             run_on;     // keep accumulating the current window
  logic [CNT_W-1:0] edge_next;  // count including this cycle's pulse
  logic             sat_next;

  logic [CNT_W-1:0] result_q;
  logic             overflow_q;
  logic             valid_q;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    terminal = 1'b0;
    run_on   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        // The terminal cycle publishes even when enable drops in it.
        terminal = (gate_q == GATE_LAST);
        if (!bus.enable) begin
          state_d = IDLE;
        end else begin
          run_on = !terminal;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Edge counter with saturation. The sat flag marks an edge that arrived
  // while the counter was already at its maximum, i.e. an edge was lost.
  // ---------------------------------------------------------------------
  always_comb begin
    edge_next = edge_q;
    sat_next  = sat_q;
    if (bus.edge_pulse) begin
      if (edge_q == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        edge_next = edge_q + 1'b1;
      end
    end
  end

  // Counters clear in IDLE, on an abandoned window and after the terminal
  // cycle, so a new window always starts from zero.
  always_ff @(posedge clk) begin
    if (!reset_n || !run_on) begin
      gate_q <= '0;
      edge_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      gate_q <= gate_q + 1'b1;
      edge_q <= edge_next;
      sat_q  <= sat_next;
    end
  end

  // ---------------------------------------------------------------------
  // Publish path
  // ---------------------------------------------------------------------
`ifdef FREQ_GATE_BCD_EN
  localparam int IW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  logic             conv_busy_q;
  logic [CNT_W-1:0] conv_val_q;   // private copy, next window counts freely
  logic             conv_ov_q;
  logic [IW-1:0]    conv_idx_q;   // bit of conv_val_q shifted in next
  logic [BCD_W-1:0] conv_bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_step;
  logic [BCD_W-1:0] result_bcd_q;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the
  // next binary bit, MSB first.
  always_comb begin
    bcd_adj = conv_bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_adj[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_adj[4*d +: 4] + 4'd3;
      end
    end
    bcd_step = {bcd_adj[BCD_W-2:0], conv_val_q[conv_idx_q]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      conv_busy_q  <= 1'b0;
      conv_val_q   <= '0;
      conv_ov_q    <= 1'b0;
      conv_idx_q   <= '0;
      conv_bcd_q   <= '0;
      result_q     <= '0;
      result_bcd_q <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (terminal) begin
        conv_busy_q <= 1'b1;
        conv_val_q  <= edge_next;
        conv_ov_q   <= sat_next;
        conv_idx_q  <= IW'(CNT_W - 1);
        conv_bcd_q  <= '0;
      end else if (conv_busy_q) begin
        conv_bcd_q <= bcd_step;
        conv_idx_q <= conv_idx_q - 1'b1;
        // Last bit: publish binary, BCD and overflow together.
        if (conv_idx_q == '0) begin
          conv_busy_q  <= 1'b0;
          result_q     <= conv_val_q;
          result_bcd_q <= bcd_step;
          overflow_q   <= conv_ov_q;
          valid_q      <= 1'b1;
        end
      end
    end
  end

  assign bus.result_bcd = result_bcd_q;
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= terminal;
      if (terminal) begin
        result_q   <= edge_next;
        overflow_q <= sat_next;
      end
    end
  end

  assign bus.result_bcd = {BCD_W{1'b0}};
`endif

  assign bus.result       = result_q;
  assign bus.overflow     = overflow_q;
  assign bus.result_valid = valid_q;
  assign bus.busy         = (state_q == COUNT);
  assign bus.state_dbg    = state_q;

endmodule
